shift_out_receiver: RTL and testbench

- Receive-side counterpart of the board's 4-wire serial display/LED shift-out link (SCLK, SDO, PEN, CLR).
- Oversamples the link with the system clock, deserialises each frame, and presents the latched parallel word with a one-cycle valid strobe.
- Used for loopback self-check of the segment/LED drivers on the board, and as a checker in the top-level bench.

---
 rtl/shift_out_receiver.sv | 153 +++++++++++++++
 tb/tb_shift_out_receiver.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_out_receiver.sv
// Deserialises the 4-wire SCLK/SDO/PEN/CLR shift-out link into a parallel word.
// Latency: a pin edge is acted on SYNC_STAGES+1 clk cycles later; pdata/pdata_valid are registered.
// No backpressure: the link cannot be stalled, so every PEN rise yields either a valid or an error pulse.
module shift_out_receiver #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int MSB_FIRST   = 1,
    parameter int INVERT      = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk_in,
    input  logic             sdo_in,
    input  logic             pen_in,
    input  logic             clr_in,
    output logic [WIDTH-1:0] pdata,
    output logic             pdata_valid,
    output logic             frame_err,
    output logic [6:0]       bit_cnt,
    output logic             busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [6:0] WIDTH_CNT = 7'(WIDTH);
    localparam logic [6:0] CNT_MAX   = 7'd127;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] sdo_sync;
    logic [SYNC_STAGES-1:0] pen_sync;
    logic [SYNC_STAGES-1:0] clr_sync;
    logic                   sclk_d;
    logic                   pen_d;

    logic sclk_s, sdo_s, pen_s, clr_s;
    logic sclk_rise, pen_rise;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt, sreg_sh;
    logic [WIDTH-1:0] pdata_nxt;
    logic [6:0]       cnt_nxt, cnt_inc;
    logic             vld_nxt, err_nxt;
    logic             shift_en;
    logic [WIDTH-1:0] sreg_upd;
    logic [6:0]       cnt_upd;

    // Synchronise every link line; reset loads idle line levels so no false edges appear.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            sdo_sync  <= '0;
            pen_sync  <= '1;
            clr_sync  <= '1;
            sclk_d    <= 1'b0;
            pen_d     <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
            sdo_sync  <= {sdo_sync[SYNC_STAGES-2:0], sdo_in};
            pen_sync  <= {pen_sync[SYNC_STAGES-2:0], pen_in};
            clr_sync  <= {clr_sync[SYNC_STAGES-2:0], clr_in};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            pen_d     <= pen_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign sdo_s     = sdo_sync[SYNC_STAGES-1];
    assign pen_s     = pen_sync[SYNC_STAGES-1];
    assign clr_s     = clr_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign pen_rise  = pen_s & ~pen_d;

    // Shift direction is fixed by MSB_FIRST; only the last WIDTH bits survive.
    assign sreg_sh = (MSB_FIRST != 0) ? {sreg[WIDTH-2:0], sdo_s}
                                      : {sdo_s, sreg[WIDTH-1:1]};
    assign cnt_inc = (bit_cnt == CNT_MAX) ? CNT_MAX : bit_cnt + 7'd1;

    // Next-state and datapath: shift first, then the PEN check sees the updated count; CLR wins over both.
    always_comb begin
        state_nxt = state;
        sreg_nxt  = sreg;
        cnt_nxt   = bit_cnt;
        pdata_nxt = pdata;
        vld_nxt   = 1'b0;
        err_nxt   = 1'b0;
        shift_en  = 1'b0;
        sreg_upd  = sreg;
        cnt_upd   = bit_cnt;

        case (state)
            IDLE:    shift_en = sclk_rise & ~pen_s;
            SHIFT:   shift_en = sclk_rise;
            default: shift_en = 1'b0;
        endcase

        if (shift_en) begin
            sreg_upd = sreg_sh;
            cnt_upd  = cnt_inc;
        end

        if (!clr_s) begin
            sreg_nxt  = '0;
            cnt_nxt   = '0;
            state_nxt = IDLE;
        end else if (pen_rise) begin
            sreg_nxt  = sreg_upd;
            cnt_nxt   = '0;
            state_nxt = IDLE;
            if (cnt_upd == WIDTH_CNT) begin
                pdata_nxt = (INVERT != 0) ? ~sreg_upd : sreg_upd;
                vld_nxt   = 1'b1;
            end else begin
                err_nxt   = 1'b1;
            end
        end else if (shift_en) begin
            sreg_nxt  = sreg_upd;
            cnt_nxt   = cnt_upd;
            state_nxt = SHIFT;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg        <= '0;
            bit_cnt     <= '0;
            pdata       <= '0;
            pdata_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            sreg        <= sreg_nxt;
            bit_cnt     <= cnt_nxt;
            pdata       <= pdata_nxt;
            pdata_valid <= vld_nxt;
            frame_err   <= err_nxt;
        end
    end

    assign busy = (state == SHIFT);

endmodule

// File: tb/tb_shift_out_receiver.sv
module tb_shift_out_receiver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sclk = 1'b0, sdo = 1'b0, pen = 1'b1, clr = 1'b1;

    logic [15:0] pdata_a, pdata_b;
    logic        pdata_valid_a, pdata_valid_b, frame_err_a, frame_err_b, busy_a, busy_b;
    logic [6:0]  bit_cnt_a, bit_cnt_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int va = 0, vb = 0, ea = 0, eb = 0;
    int first_va = -1;

    bit          q[$];
    logic [15:0] exp_a = 16'h0000;
    logic [15:0] exp_b = 16'h0000;

    always #5 clk = ~clk;

    shift_out_receiver #(.WIDTH(16), .SYNC_STAGES(2), .MSB_FIRST(1), .INVERT(0)) dut_a (
        .clk(clk), .rst(rst), .sclk_in(sclk), .sdo_in(sdo), .pen_in(pen), .clr_in(clr),
        .pdata(pdata_a), .pdata_valid(pdata_valid_a), .frame_err(frame_err_a),
        .bit_cnt(bit_cnt_a), .busy(busy_a)
    );

    shift_out_receiver #(.WIDTH(16), .SYNC_STAGES(2), .MSB_FIRST(0), .INVERT(1)) dut_b (
        .clk(clk), .rst(rst), .sclk_in(sclk), .sdo_in(sdo), .pen_in(pen), .clr_in(clr),
        .pdata(pdata_b), .pdata_valid(pdata_valid_b), .frame_err(frame_err_b),
        .bit_cnt(bit_cnt_b), .busy(busy_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference word: first bit received is the MSB (or LSB), optionally complemented.
    function automatic logic [15:0] model_word(input bit msb_first, input bit inv);
        logic [15:0] w;
        w = '0;
        for (int i = 0; i < 16; i++) begin
            if (msb_first) w[15-i] = q[i];
            else           w[i]    = q[i];
        end
        return inv ? ~w : w;
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            cyc++;
            if (pdata_valid_a) begin
                va++;
                if (first_va < 0) first_va = cyc;
            end
            if (pdata_valid_b) vb++;
            if (frame_err_a) ea++;
            if (frame_err_b) eb++;
            if (pdata_valid_a || frame_err_a) chk("excl_a", 64'(pdata_valid_a & frame_err_a), 64'd0);
            if (pdata_valid_b || frame_err_b) chk("excl_b", 64'(pdata_valid_b & frame_err_b), 64'd0);
        end
    endtask

    task automatic send_bit(input bit b, input int hp);
        sdo = b;
        tick(hp);
        sclk = 1'b1;
        q.push_back(b);
        tick(hp);
        sclk = 1'b0;
    endtask

    // PEN rise (pen may already be high for a coincident edge) and check the outcome.
    task automatic pen_end(input bit check_lat);
        int n, start, va0, vb0, ea0, eb0;
        bit good;
        n = q.size();
        good = (n == 16);
        if (good) begin
            exp_a = model_word(1'b1, 1'b0);
            exp_b = model_word(1'b0, 1'b1);
        end
        va0 = va; vb0 = vb; ea0 = ea; eb0 = eb;
        pen = 1'b1;
        start = cyc;
        first_va = -1;
        tick(8);
        chk("valid_cnt_a", 64'(va - va0), good ? 64'd1 : 64'd0);
        chk("valid_cnt_b", 64'(vb - vb0), good ? 64'd1 : 64'd0);
        chk("err_cnt_a", 64'(ea - ea0), good ? 64'd0 : 64'd1);
        chk("err_cnt_b", 64'(eb - eb0), good ? 64'd0 : 64'd1);
        chk("pdata_a", 64'(pdata_a), 64'(exp_a));
        chk("pdata_b", 64'(pdata_b), 64'(exp_b));
        chk("bit_cnt_after", 64'(bit_cnt_a), 64'd0);
        chk("busy_after", 64'(busy_b), 64'd0);
        if (check_lat) chk("valid_latency", 64'(first_va - start), 64'd3);
        q.delete();
        sclk = 1'b0;
        pen = 1'b0;
        tick(4);
    endtask

    // Bits go out from val[n-1] down to val[0], or val[0] upward when lsb is set.
    task automatic send_frame(input logic [63:0] val, input int n, input int hp,
                              input bit lsb, input bit coinc, input bit check_lat);
        int nb;
        bit b;
        if (pen) begin
            pen = 1'b0;
            tick(4);
        end
        nb = coinc ? n - 1 : n;
        for (int i = 0; i < nb; i++) begin
            b = lsb ? val[i] : val[n-1-i];
            send_bit(b, hp);
        end
        if (coinc) begin
            b = lsb ? val[n-1] : val[0];
            sdo = b;
            tick(hp);
            sclk = 1'b1;
            q.push_back(b);
        end else begin
            tick(4);
            chk("bit_cnt_pre_a", 64'(bit_cnt_a), 64'(n > 127 ? 127 : n));
            chk("bit_cnt_pre_b", 64'(bit_cnt_b), 64'(n > 127 ? 127 : n));
            chk("busy_pre", 64'(busy_a), 64'(n > 0));
        end
        pen_end(check_lat);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int e0;
        tick(3);
        rst = 1'b0;

        // Idle lines after reset.
        e0 = ea + eb + va + vb;
        tick(20);
        chk("idle_pdata_a", 64'(pdata_a), 64'h0);
        chk("idle_pdata_b", 64'(pdata_b), 64'h0);
        chk("idle_bit_cnt", 64'(bit_cnt_a), 64'd0);
        chk("idle_busy", 64'(busy_a), 64'd0);
        chk("idle_pulses", 64'(ea + eb + va + vb - e0), 64'd0);

        // Reset mid-frame after 5 bits.
        pen = 1'b0;
        tick(4);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 4);
        tick(4);
        chk("partial_bit_cnt", 64'(bit_cnt_a), 64'd5);
        e0 = ea + eb;
        rst = 1'b1;
        tick(1);
        chk("rst_bit_cnt", 64'(bit_cnt_a), 64'd0);
        chk("rst_busy", 64'(busy_a), 64'd0);
        rst = 1'b0;
        q.delete();
        tick(6);
        chk("rst_no_err", 64'(ea + eb - e0), 64'd0);

        // Directed frames.
        send_frame(64'hA5C3, 16, 4, 1'b0, 1'b0, 1'b1);
        send_frame(64'h00FF, 16, 4, 1'b1, 1'b0, 1'b0);
        send_frame(64'hA5C3, 16, 3, 1'b0, 1'b0, 1'b0);
        send_frame(64'h7FFF, 15, 4, 1'b0, 1'b0, 1'b0);
        chk("short_keeps_a", 64'(pdata_a), 64'hA5C3);
        send_frame(64'h1FFFF, 17, 3, 1'b0, 1'b0, 1'b0);

        // CLR after 8 bits, then a clean frame.
        for (int i = 0; i < 8; i++) send_bit(i[0], 4);
        e0 = ea + eb + va + vb;
        clr = 1'b0;
        tick(6);
        chk("clr_bit_cnt", 64'(bit_cnt_a), 64'd0);
        chk("clr_busy", 64'(busy_b), 64'd0);
        chk("clr_pdata", 64'(pdata_a), 64'hA5C3);
        clr = 1'b1;
        q.delete();
        tick(6);
        chk("clr_no_pulse", 64'(ea + eb + va + vb - e0), 64'd0);
        send_frame(64'h1234, 16, 4, 1'b0, 1'b0, 1'b0);

        // Coincident final SCLK rise and PEN rise; back-to-back frames.
        send_frame(64'hFFFF, 16, 4, 1'b0, 1'b1, 1'b0);
        send_frame(64'h0001, 16, 3, 1'b0, 1'b0, 1'b0);
        send_frame(64'h8000, 16, 3, 1'b0, 1'b0, 1'b0);
        chk("b2b_final", 64'(pdata_a), 64'h8000);

        // Randomised frames around the nominal length.
        for (int k = 0; k < 8; k++) begin
            send_frame(64'($urandom), $urandom_range(14, 18), $urandom_range(3, 6),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
